// File: rtl/fadd_acc.sv
// fadd_acc: sequential binary32 accumulator fed by the FMul stage.
// Products arrive over a valid/ready handshake. Each one passes through
// IDLE -> ALIGN -> ADD -> NORM and is folded into the accumulator. The element
// flagged in_last closes the sum, and the block then shows it in DONE until
// the consumer takes it.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   in_valid/in_ready - input handshake; in_data = binary32 addend, in_last = closes sum
//   out_valid/out_ready - output handshake; out_data = binary32 sum,
//                         out_count = number of elements (saturating)
// Configuration macro: FADD_ACC_DENORM_EN.
//   Defined   -> subnormals are accepted and produced (gradual underflow).
//   Undefined -> subnormals are flushed to signed zero on input and on output.
module fadd_acc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] CANON_NAN = 32'h7F80_0001;

    // Leading-zero count of a 27-bit field, measured from bit 26.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) begin
                n = 5'(26 - i);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    state_t            state_r, state_next_s;
    logic              in_ready_r, out_valid_r;
    logic [31:0]       op_r, acc_r;
    logic              last_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              sign_r, eff_sub_r, spec_r;
    logic [31:0]       spec_val_r;
    logic signed [9:0] exp_r;
    logic [26:0]       ma_r, mb_r;
    logic [27:0]       sum_r;

    logic              accept_s;
    assign accept_s = in_valid && in_ready_r;

    // Next-state decode of the accumulate FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE:  if (accept_s) state_next_s = S_ALIGN; else state_next_s = S_IDLE;
            S_ALIGN: state_next_s = S_ADD;
            S_ADD:   state_next_s = S_NORM;
            S_NORM:  if (last_r) state_next_s = S_DONE; else state_next_s = S_IDLE;
            S_DONE:  if (out_ready) state_next_s = S_IDLE; else state_next_s = S_DONE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register plus registered handshake decodes (no path from out_ready to in_ready).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == S_IDLE);
            out_valid_r <= (state_next_s == S_DONE);
        end
    end

    // ALIGN: order operands by magnitude, unpack, shift the smaller, detect specials.
    logic [31:0]       big_s, small_s;
    logic signed [9:0] exp_big_s, exp_small_s, diff_s;
    logic [23:0]       man_big_s, man_small_s;
    logic [52:0]       wide_a_s;
    logic [26:0]       mb_shift_s;
    logic              nan_acc_s, nan_op_s, inf_acc_s, inf_op_s, spec_s;
    logic [31:0]       spec_val_s;
    always_comb begin
        big_s   = acc_r;
        small_s = op_r;
        if (op_r[30:0] > acc_r[30:0]) begin
            big_s   = op_r;
            small_s = acc_r;
        end else begin
            big_s   = acc_r;
            small_s = op_r;
        end
        // Zero/subnormal operands sit at exponent 1 with no hidden bit.
        exp_big_s   = (big_s[30:23] == 8'd0)   ? 10'sd1 : $signed({2'b00, big_s[30:23]});
        exp_small_s = (small_s[30:23] == 8'd0) ? 10'sd1 : $signed({2'b00, small_s[30:23]});
`ifdef FADD_ACC_DENORM_EN
        man_big_s   = {(big_s[30:23] != 8'd0), big_s[22:0]};
        man_small_s = {(small_s[30:23] != 8'd0), small_s[22:0]};
`else
        man_big_s   = (big_s[30:23] == 8'd0)   ? 24'd0 : {1'b1, big_s[22:0]};
        man_small_s = (small_s[30:23] == 8'd0) ? 24'd0 : {1'b1, small_s[22:0]};
`endif
        diff_s   = exp_big_s - exp_small_s;
        wide_a_s = {man_small_s, 29'd0} >> diff_s[5:0];
        if (diff_s >= 10'sd26) begin
            mb_shift_s = {26'd0, |man_small_s};
        end else begin
            mb_shift_s = {wide_a_s[52:27], wide_a_s[26] | (|wide_a_s[25:0])};
        end
        nan_acc_s  = (acc_r[30:23] == 8'hFF) && (acc_r[22:0] != 23'd0);
        nan_op_s   = (op_r[30:23] == 8'hFF) && (op_r[22:0] != 23'd0);
        inf_acc_s  = (acc_r[30:0] == 31'h7F80_0000);
        inf_op_s   = (op_r[30:0] == 31'h7F80_0000);
        spec_s     = nan_acc_s || nan_op_s || inf_acc_s || inf_op_s;
        spec_val_s = CANON_NAN;
        if (nan_acc_s || nan_op_s) begin
            spec_val_s = CANON_NAN;
        end else if (inf_acc_s && inf_op_s && (acc_r[31] != op_r[31])) begin
            spec_val_s = CANON_NAN;
        end else if (inf_acc_s) begin
            spec_val_s = acc_r;
        end else begin
            spec_val_s = op_r;
        end
    end

    // NORM: normalise, optional gradual underflow, round to nearest even, pack.
    logic [4:0]        lz_s;
    logic [26:0]       norm0_s, norm_s;
    logic signed [9:0] e_n_s, e_r_s, sh_s;
    logic [53:0]       wide_n_s;
    logic              rnd_s;
    logic [24:0]       m25_s;
    logic [23:0]       mant_s;
    logic [31:0]       res_s;
    always_comb begin
        lz_s     = lzc27(sum_r[26:0]);
        sh_s     = 10'sd0;
        wide_n_s = 54'd0;
        if (sum_r[27]) begin
            norm0_s = {sum_r[27:2], |sum_r[1:0]};
            e_n_s   = exp_r + 10'sd1;
        end else begin
            norm0_s = sum_r[26:0] << lz_s;
            e_n_s   = exp_r - $signed({5'd0, lz_s});
        end
        norm_s = norm0_s;
`ifdef FADD_ACC_DENORM_EN
        // Tiny results are shifted back right into subnormal position, keeping sticky.
        if (e_n_s < 10'sd1) begin
            sh_s = 10'sd1 - e_n_s;
            if (sh_s >= 10'sd27) begin
                norm_s = {26'd0, |norm0_s};
            end else begin
                wide_n_s = {norm0_s, 27'd0} >> sh_s[5:0];
                norm_s   = {wide_n_s[53:28], wide_n_s[27] | (|wide_n_s[26:0])};
            end
            e_n_s = 10'sd1;
        end else begin
            norm_s = norm0_s;
        end
`endif
        rnd_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        m25_s = {1'b0, norm_s[26:3]} + {24'd0, rnd_s};
        if (m25_s[24]) begin
            mant_s = m25_s[24:1];
            e_r_s  = e_n_s + 10'sd1;
        end else begin
            mant_s = m25_s[23:0];
            e_r_s  = e_n_s;
        end
        // Exact cancellation yields +0; like-signed zeros keep their sign.
        if (sum_r == 28'd0) begin
            res_s = {(~eff_sub_r) & sign_r, 31'd0};
        end else if (e_r_s >= 10'sd255) begin
            res_s = {sign_r, 8'hFF, 23'd0};
        end else if (e_r_s <= 10'sd0) begin
            res_s = {sign_r, 31'd0};
        end else begin
            // A subnormal result has no hidden bit and encodes exponent 0.
            res_s = {sign_r, (mant_s[23] ? e_r_s[7:0] : 8'd0), mant_s[22:0]};
        end
    end

    // Datapath registers: operand capture, count, stage pipeline and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r       <= 32'd0;
            last_r     <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            acc_r      <= 32'd0;
            sign_r     <= 1'b0;
            eff_sub_r  <= 1'b0;
            spec_r     <= 1'b0;
            spec_val_r <= 32'd0;
            exp_r      <= 10'sd0;
            ma_r       <= 27'd0;
            mb_r       <= 27'd0;
            sum_r      <= 28'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r   <= in_data;
                        last_r <= in_last;
                        if (&cnt_r) cnt_r <= cnt_r;
                        else        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        op_r <= op_r;
                    end
                end
                S_ALIGN: begin
                    sign_r     <= big_s[31];
                    eff_sub_r  <= big_s[31] ^ small_s[31];
                    exp_r      <= exp_big_s;
                    ma_r       <= {man_big_s, 3'b000};
                    mb_r       <= mb_shift_s;
                    spec_r     <= spec_s;
                    spec_val_r <= spec_val_s;
                end
                S_ADD: begin
                    if (eff_sub_r) sum_r <= {1'b0, ma_r} - {1'b0, mb_r};
                    else           sum_r <= {1'b0, ma_r} + {1'b0, mb_r};
                end
                S_NORM: begin
                    acc_r <= spec_r ? spec_val_r : res_s;
                end
                S_DONE: begin
                    if (out_ready) begin
                        acc_r <= 32'd0;
                        cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = acc_r;
    assign out_count = cnt_r;

endmodule

// File: tb/tb_fadd_acc.sv
module tb_fadd_acc;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [15:0] out_count;

    int checks = 0;
    int errors = 0;

    fadd_acc #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          n;
        logic [31:0] d0, d1, d2;
        logic [31:0] exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int t;
        t = 0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Waits for the result after the last element, checks latency, data and count, then handshakes.
    task automatic collect(input string name, input logic [31:0] exp_d, input logic [15:0] exp_c);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, 32'd3);
        chk({name, "_data"}, out_data, exp_d);
        chk({name, "_count"}, {16'd0, out_count}, {16'd0, exp_c});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_post_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_post_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        vecs[0]  = '{"acc123",   3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40C00000, 16'd3};
        vecs[1]  = '{"tie_even", 2, 32'h3F800000, 32'h33800000, 32'h0,        32'h3F800000, 16'd2};
        vecs[2]  = '{"tie_up",   2, 32'h3F800000, 32'h34400000, 32'h0,        32'h3F800002, 16'd2};
        vecs[3]  = '{"inf_inf",  2, 32'h7F800000, 32'hFF800000, 32'h0,        32'h7F800001, 16'd2};
        vecs[4]  = '{"ovf",      2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0,        32'h7F800000, 16'd2};
        vecs[5]  = '{"cancel",   2, 32'h3FC00000, 32'hBFC00000, 32'h0,        32'h00000000, 16'd2};
`ifdef FADD_ACC_DENORM_EN
        vecs[6]  = '{"sub_in",   1, 32'h00000001, 32'h0,        32'h0,        32'h00000001, 16'd1};
        vecs[7]  = '{"sub_out",  2, 32'h00800001, 32'h80800000, 32'h0,        32'h00000001, 16'd2};
`else
        vecs[6]  = '{"sub_in",   1, 32'h00000001, 32'h0,        32'h0,        32'h00000000, 16'd1};
        vecs[7]  = '{"sub_out",  2, 32'h00800001, 32'h80800000, 32'h0,        32'h00000000, 16'd2};
`endif
        vecs[8]  = '{"neg_sub",  2, 32'hC0000000, 32'h3F800000, 32'h0,        32'hBF800000, 16'd2};
        vecs[9]  = '{"nan_keep", 3, 32'h7FC00000, 32'h3F800000, 32'h40000000, 32'h7F800001, 16'd3};
        vecs[10] = '{"rnd_carry",2, 32'h3FFFFFFF, 32'h33800000, 32'h0,        32'h40000000, 16'd2};
        vecs[11] = '{"far_sticky",2,32'h3FC00000, 32'h00800000, 32'h0,        32'h3FC00000, 16'd2};

        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_count", {16'd0, out_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].d0, vecs[i].n == 1);
            if (vecs[i].n >= 2) send(vecs[i].d1, vecs[i].n == 2);
            if (vecs[i].n >= 3) send(vecs[i].d2, 1'b1);
            collect(vecs[i].name, vecs[i].exp_data, vecs[i].exp_cnt);
        end

        // Output held under backpressure: data stable, no input accepted.
        send(32'h40400000, 1'b1);
        repeat (3) @(negedge clk);
        held = out_data;
        chk("hold_value", held, 32'h40400000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_data", out_data, held);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset pulse while the operand is in the ADD stage.
        send(32'h40000000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_out_count", {16'd0, out_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(32'h3F800000, 1'b1);
        collect("after_rst", 32'h3F800000, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fadd_acc.md
# fadd_acc

Sequential single-precision floating-point accumulator that sits directly downstream of the combinational `FMul` stage in the dot-product datapath. It consumes a stream of IEEE 754 binary32 products over a valid/ready handshake and sums them with a multi-cycle align/add/normalize FSM. On the element flagged `in_last`, it presents the rounded sum and the element count on an output valid/ready port. Special-value encodings match `FMul`: the canonical NaN is `0x7F800001`, and overflow produces signed infinity.

## Interface
- `CNT_W`, default 16: width of the element counter. The counter saturates at all-ones.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: `in_data`/`in_last` are valid.
- `in_ready` output 1: the block accepts an element this cycle.
- `in_data` input 32: binary32 addend, typically `FMul.out`.
- `in_last` input 1: this element closes the current sum.
- `out_valid` output 1: `out_data`/`out_count` are valid.
- `out_ready` input 1: the consumer accepts the result.
- `out_data` output 32: binary32 sum.
- `out_count` output CNT_W: number of elements in the sum.

## Operation
- FSM states: IDLE, ALIGN, ADD, NORM, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, latch the operand and the last flag, increment the count, go to ALIGN.
  - ALIGN: unpack the operand and the accumulator. Swap so that exponent(A) ≥ exponent(B). Right-shift mantissa(B) by the exponent difference into a 27-bit {mant, G, R, S} field.
    - Shift ≥ 26 collapses B to sticky only.
  - ADD: add the mantissas if the signs are equal, otherwise subtract (A−B, magnitude-ordered); produce a 28-bit result.
  - NORM: handle carry-out with a right shift by 1, or leading zeros with a left shift via leading-zero count, adjusting the exponent. Then round to nearest, ties-to-even, from G/R/S.
    - A rounding carry renormalises.
    - Write the result to the accumulator.
    - Next state is DONE if the last flag is set, else IDLE.
  - DONE: `out_valid`=1, `out_data`=accumulator, `out_count`=count. On `out_ready`: clear the accumulator to +0 and the count to 0, go to IDLE.
- Special cases, evaluated in ALIGN; the result is written unchanged in NORM:
  - Any NaN operand gives `0x7F800001`.
  - +Inf plus −Inf gives `0x7F800001`.
  - One Inf operand gives that Inf.
  - Once the accumulator is NaN it stays NaN until cleared.
- Exponent handling:
  - The exponent is held in 10-bit signed form internally.
  - A post-round exponent ≥ 255 gives signed infinity.
  - A post-round exponent ≤ 0 gives signed zero, unless `FADD_ACC_DENORM_EN` is defined.
- Zero sign:
  - Exact cancellation gives +0.
  - (−0)+(−0) gives −0.
- Subnormal inputs are treated as signed zero, unless `FADD_ACC_DENORM_EN` is defined.
- The accumulator initial value is +0 (`0x00000000`).

## Timing
- Reset values:
  - `in_ready`=0 while `rst_n` is low, 1 after reset (state IDLE).
  - `out_valid`=0.
  - `out_data`=0.
  - `out_count`=0.
  - Accumulator=+0, count=0.
- Throughput: one element per 4 cycles (IDLE → ALIGN → ADD → NORM).
- `in_ready` is high only in IDLE. It is a registered state decode with no combinational path from `out_ready`.
- Latency: if the last element is accepted at edge T, `out_valid` rises after edge T+3, i.e. it is visible in cycle T+3 to T+4.
- `out_data`/`out_count` are held stable while `out_valid` is high and `out_ready` is low.
- The earliest next input accept is the cycle after the output handshake. There are no simultaneous in/out handshakes.
- A sum with `in_last` on its first element outputs that element, rounded or flushed, with count 1.
- Counter saturates at 2^CNT_W−1.
- `rst_n` asserted mid-operation: immediately return to IDLE. The in-flight operand and the partial sum are discarded, and the outputs go to their reset values.

## Configuration
- Macro `FADD_ACC_DENORM_EN`.
- Defined:
  - Subnormal inputs enter with implicit bit 0 and exponent 1.
  - NORM produces gradual underflow: results with exponent ≤ 0 are right-shifted into a subnormal with correct G/R/S rounding.
  - Adds one extra right-shifter of about 24 bits.
- Undefined: flush-to-zero on both input and output, keeping the sign.

## Test plan
- Accumulation: `0x3F800000` (1.0), `0x40000000` (2.0), `0x40400000` (3.0, last) -> `out_data`=`0x40C00000` (6.0), `out_count`=3.
- Rounding ties-to-even:
  - `0x3F800000` + `0x33800000` (last) -> `0x3F800000`.
  - `0x3F800000` + `0x34400000` (last) -> `0x3F800002`.
- Specials:
  - `0x7F800000` + `0xFF800000` (last) -> `0x7F800001`.
  - `0x7F7FFFFF` + `0x7F7FFFFF` (last) -> `0x7F800000`.
- Cancellation: `0x3FC00000` + `0xBFC00000` (last) -> `0x00000000`.
- Subnormal input: `0x00000001` alone, last -> `0x00000000` without the macro, `0x00000001` with it.
- Handshake/reset:
  - Hold `out_ready`=0 for 5 cycles -> `out_data` stable and `in_ready`=0 throughout.
  - Pulse `rst_n` low during ADD -> next sum of 1.0 (last) returns `0x3F800000`, count 1.
